// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control unit.
// It holds the FSM state encoding and the default operand and accumulator widths.
package mult_pkg;

  localparam int N_DEF = 4;
  localparam int ACC_W = 2 * N_DEF + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter for the multiplier FSM.
// It has a synchronous clear and an enable, and flags when the last multiplier bit is being processed.
module mult_bit_counter #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (en_i)  count_d = count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign last_o = (count_q == CW'(N - 1));

endmodule

// File: rtl/mult_control.sv
// Control FSM for the shift-add multiplier. It drives the Load/Sh/Ad strobes into the ACC register
// and handshakes with the system through St and Done.
module mult_control
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Sh,
  output logic Ad,
  output logic Busy,
  output logic Done
);

  state_e state_q, state_d;
  logic   last;

  // The counter advances only on non-final shifts, so it never wraps.
  mult_bit_counter #(.N(N)) u_counter (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr_i  (state_q == LOAD),
    .en_i   ((state_q == SHIFT) && !last),
    .last_o (last)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output and the next state get a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    Load    = 1'b0;
    Sh      = 1'b0;
    Ad      = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      IDLE:  if (St) state_d = LOAD;
      LOAD: begin
        Load    = 1'b1;
        Busy    = 1'b1;
        state_d = EVAL;
      end
      // ACC presents the fresh LSB one cycle after Load/Sh, so M is sampled here.
      EVAL: begin
        Busy    = 1'b1;
        state_d = M ? ADD : SHIFT;
      end
      ADD: begin
        Ad      = 1'b1;
        Busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        Sh      = 1'b1;
        Busy    = 1'b1;
        state_d = last ? DONE : EVAL;
      end
      DONE: begin
        Done = 1'b1;
        if (!St) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control. A behavioural ACC drives M; a scoreboard holds the expected
// product, latency and strobe counts for each operation and a negedge monitor checks them.
module tb_mult_control;

  localparam int N = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic St  = 1'b0;
  logic M;
  logic Load, Sh, Ad, Busy, Done;

  always #5 Clk = ~Clk;

  mult_control #(.N(N)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (St),
    .M    (M),
    .Load (Load),
    .Sh   (Sh),
    .Ad   (Ad),
    .Busy (Busy),
    .Done (Done)
  );

  // Accumulator with its 4-bit adder: {carry+upper N bits, multiplier bits}.
  logic [2*N:0]   acc = '0;
  logic [N-1:0]   mcand = '0;
  logic [N-1:0]   mplier = '0;

  always @(posedge Clk) begin
    if (Load)    acc <= {{(N+1){1'b0}}, mplier};
    else if (Ad) acc <= {({1'b0, acc[2*N-1:N]} + {1'b0, mcand}), acc[N-1:0]};
    else if (Sh) acc <= acc >> 1;
  end
  assign M = acc[0];

  typedef struct {
    logic [2*N:0] product;
    int           latency;
    int           ads;
    int           shs;
  } exp_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.product = (2*N+1)'(int'(a) * int'(b));
    e.latency = 2 + 2 * N + popcount(b);
    e.ads     = popcount(b);
    e.shs     = N;
    return e;
  endfunction

  // Monitor: tracks each operation from its Load and checks it when Done rises.
  bit active = 0;
  bit done_q = 0;
  int cyc, n_ad, n_sh;

  always @(negedge Clk) begin
    check("strobes_onehot0", 32'($onehot0({Load, Sh, Ad})), 32'd1);
    check("busy_done_excl", 32'(Busy && Done), 32'd0);
    if (Busy && !Load && !Sh && !Ad) check("m_known_in_eval", 32'($isunknown(M)), 32'd0);
    if (Rst) begin
      active = 0;
    end else if (Load) begin
      active = 1;
      cyc    = 1;
      n_ad   = 0;
      n_sh   = 0;
    end else if (active) begin
      cyc++;
      n_ad += int'(Ad);
      n_sh += int'(Sh);
    end
    if (Done && !done_q && active) begin
      exp_t e;
      active = 0;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("product", 32'(acc), 32'(e.product));
        check("done_latency", 32'(cyc), 32'(e.latency));
        check("ad_pulses", 32'(n_ad), 32'(e.ads));
        check("sh_pulses", 32'(n_sh), 32'(e.shs));
      end
    end
    done_q = Done;
  end

  // Raise St from IDLE; Load must appear in the following cycle.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    mcand  = a;
    mplier = b;
    sb_q.push_back(model(a, b));
    St = 1'b1;
    @(negedge Clk);
    check("load_after_st", 32'(Load), 32'd1);
  endtask

  task automatic finish_op(input int hold, input bit toggle);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1;
      else if (toggle) St = 1'($urandom_range(0, 1));
    end
    check("done_timeout", 32'(seen), 32'd1);
    St = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check("done_held", 32'(Done), 32'd1);
      check("no_reload", 32'(Load), 32'd0);
    end
    St = 1'b0;
    @(negedge Clk);
    check("idle_after_st_drop", 32'({Done, Busy}), 32'd0);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold, input bit toggle);
    start_op(a, b);
    finish_op(hold, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with St high: all outputs stay low, then the operation starts after release.
    mcand  = 4'd3;
    mplier = 4'd6;
    Rst = 1'b1;
    St  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("reset_outputs", 32'({Load, Sh, Ad, Busy, Done}), 32'd0);
    end
    sb_q.push_back(model(mcand, mplier));
    Rst = 1'b0;
    @(negedge Clk);
    check("load_after_reset", 32'(Load), 32'd1);
    finish_op(0, 0);

    run_op(4'd7,  4'd5,  3, 0);
    run_op(4'd9,  4'd0,  0, 0);
    run_op(4'd6,  4'd15, 0, 0);
    run_op(4'd15, 4'd15, 2, 1);

    // Reset during the ADD for the second multiplier bit.
    begin
      int  ads = 0;
      bit  hit = 0;
      start_op(4'd5, 4'd15);
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge Clk);
        if (Ad) begin
          ads++;
          if (ads == 2) hit = 1;
        end
      end
      check("second_add_seen", 32'(hit), 32'd1);
      Rst = 1'b1;
      St  = 1'b0;
      void'(sb_q.pop_back());
      @(negedge Clk);
      check("midop_reset_outputs", 32'({Load, Sh, Ad, Busy, Done}), 32'd0);
      Rst = 1'b0;
      @(negedge Clk);
      check("idle_after_midop_reset", 32'({Load, Busy, Done}), 32'd0);
    end
    run_op(4'd11, 4'd13, 0, 0);

    for (int k = 0; k < 20; k++)
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
